// File: rtl/seg7_mux_counter.sv
// seg7_mux_counter: prescaled multi-digit BCD counter with a time-multiplexed
// seven-segment display driver.
//
// Optional feature: define SEG7_MUX_DOWN_EN to honour the 'down' input
// (decrement with borrow). When the macro is undefined, the counter is up-only
// and no borrow logic is built.
//
// The display outputs are registered from next-state values, so after every
// edge digit_sel selects scan position k and segments shows the decode of
// digit k of the bcd_count visible in that same cycle.
module seg7_mux_counter #(
  parameter int unsigned MAX_COUNT     = 10_000_000,
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned REFRESH_COUNT = 10_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  pause,
  input  logic                  down,
  output logic [6:0]            segments,
  output logic [DIGITS-1:0]     digit_sel,
  output logic [4*DIGITS-1:0]   bcd_count,
  output logic                  tick,
  output logic                  wrap
);

  localparam int unsigned PW = $clog2(MAX_COUNT + 1);
  localparam int unsigned RW = $clog2(REFRESH_COUNT + 1);
  localparam int unsigned SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0] P_MAX    = PW'(MAX_COUNT);
  localparam logic [RW-1:0] R_MAX    = RW'(REFRESH_COUNT);
  localparam logic [SW-1:0] S_LAST   = SW'(DIGITS - 1);
  localparam logic [6:0]    SEG_ZERO = 7'b0111111;

  logic [PW-1:0]          presc_q,   presc_d;
  logic [RW-1:0]          refresh_q, refresh_d;
  logic [SW-1:0]          scan_q,    scan_d;
  logic [4*DIGITS-1:0]    cnt_q,     cnt_d;
  logic                   tick_q,    tick_d;
  logic                   wrap_q,    wrap_d;
  logic [6:0]             seg_q,     seg_d;
  logic [DIGITS-1:0]      sel_q,     sel_d;

  logic                   step;
  logic [4*DIGITS-1:0]    inc_val;
  logic                   inc_wrap;
  logic [4*DIGITS-1:0]    step_val;
  logic                   step_wrap;
  logic [3:0]             cur_digit;

  // Seven-segment decode, bit order g..a.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // A count step happens on the prescaler terminal edge unless paused or cleared.
  assign step = (presc_q == P_MAX) && !pause && !clear;

  // BCD increment with ripple carry; carry out of the top digit means wrap.
  always_comb begin
    logic carry;
    inc_val = cnt_q;
    carry   = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (cnt_q[4*i +: 4] >= 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
    inc_wrap = carry;
  end

`ifdef SEG7_MUX_DOWN_EN
  logic [4*DIGITS-1:0] dec_val;
  logic                dec_wrap;

  // BCD decrement with ripple borrow; borrow out of the top digit means wrap.
  always_comb begin
    logic borrow;
    dec_val = cnt_q;
    borrow  = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (cnt_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else if (cnt_q[4*i +: 4] > 4'd9) begin
          dec_val[4*i +: 4] = 4'd9;
          borrow            = 1'b0;
        end else begin
          dec_val[4*i +: 4] = cnt_q[4*i +: 4] - 4'd1;
          borrow            = 1'b0;
        end
      end
    end
    dec_wrap = borrow;
  end

  assign step_val  = down ? dec_val  : inc_val;
  assign step_wrap = down ? dec_wrap : inc_wrap;
`else
  logic unused_down;

  assign unused_down = down;
  assign step_val    = inc_val;
  assign step_wrap   = inc_wrap;
`endif

  // Next-state for prescaler, count, strobes, scan and display registers.
  always_comb begin
    presc_d   = presc_q;
    cnt_d     = cnt_q;
    tick_d    = 1'b0;
    wrap_d    = 1'b0;
    refresh_d = refresh_q;
    scan_d    = scan_q;
    sel_d     = '0;
    cur_digit = '0;

    if (clear) begin
      presc_d = '0;
      cnt_d   = '0;
    end else if (!pause) begin
      presc_d = (presc_q == P_MAX) ? '0 : presc_q + 1'b1;
      if (step) begin
        cnt_d  = step_val;
        tick_d = 1'b1;
        wrap_d = step_wrap;
      end
    end

    if (refresh_q == R_MAX) begin
      refresh_d = '0;
      scan_d    = (scan_q == S_LAST) ? '0 : scan_q + 1'b1;
    end else begin
      refresh_d = refresh_q + 1'b1;
    end

    for (int unsigned i = 0; i < DIGITS; i++) begin
      sel_d[i] = (scan_d == SW'(i));
      if (scan_d == SW'(i)) begin
        cur_digit = cnt_d[4*i +: 4];
      end
    end
    seg_d = seg_decode(cur_digit);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q   <= '0;
      refresh_q <= '0;
      scan_q    <= '0;
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
      seg_q     <= SEG_ZERO;
      sel_q     <= DIGITS'(1);
    end else begin
      presc_q   <= presc_d;
      refresh_q <= refresh_d;
      scan_q    <= scan_d;
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      wrap_q    <= wrap_d;
      seg_q     <= seg_d;
      sel_q     <= sel_d;
    end
  end

  assign segments  = seg_q;
  assign digit_sel = sel_q;
  assign bcd_count = cnt_q;
  assign tick      = tick_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_seg7_mux_counter.sv
// Testbench for seg7_mux_counter (MAX_COUNT=3, DIGITS=2, REFRESH_COUNT=1).
// The reference model keeps the count as a plain integer 0..99 and derives
// BCD nibbles, digit selects and segment patterns arithmetically.
module tb_seg7_mux_counter;

  localparam int MC   = 3;
  localparam int DG   = 2;
  localparam int RC   = 1;
  localparam int MODV = 100;

  logic            clk = 1'b0;
  logic            reset, clear, pause, down;
  logic [6:0]      segments;
  logic [DG-1:0]   digit_sel;
  logic [4*DG-1:0] bcd_count;
  logic            tick, wrap;

  int n_checks = 0;
  int n_pass   = 0;

  int m_p, m_r, m_s, m_c;
  bit m_tick, m_wrap;

  logic [6:0] SEG [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                           7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                           7'b1111111, 7'b1101111};

  seg7_mux_counter #(.MAX_COUNT(MC), .DIGITS(DG), .REFRESH_COUNT(RC)) dut (
    .clk(clk), .reset(reset), .clear(clear), .pause(pause), .down(down),
    .segments(segments), .digit_sel(digit_sel), .bcd_count(bcd_count),
    .tick(tick), .wrap(wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [4*DG-1:0] to_bcd(input int v);
    logic [4*DG-1:0] r;
    int pw;
    r  = '0;
    pw = 1;
    for (int i = 0; i < DG; i++) begin
      r[4*i +: 4] = 4'((v / pw) % 10);
      pw = pw * 10;
    end
    return r;
  endfunction

  function automatic int digit_of(input int v, input int pos);
    int pw;
    pw = 1;
    for (int i = 0; i < pos; i++) pw = pw * 10;
    return (v / pw) % 10;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drive one set of inputs for one clock, advance the model, then compare.
  task automatic cyc(input bit rst, input bit clr, input bit pse, input bit dn);
    bit stp, dd;
    logic [DG-1:0] es;
    reset = rst; clear = clr; pause = pse; down = dn;
    @(posedge clk);
    if (rst) begin
      m_p = 0; m_r = 0; m_s = 0; m_c = 0; m_tick = 0; m_wrap = 0;
    end else begin
      stp = (m_p == MC) && !pse && !clr;
      dd  = 1'b0;
`ifdef SEG7_MUX_DOWN_EN
      dd  = dn;
`endif
      m_wrap = 0;
      if (clr) begin
        m_p = 0; m_c = 0;
      end else if (!pse) begin
        m_p = (m_p == MC) ? 0 : m_p + 1;
      end
      if (stp) begin
        if (dd) begin
          m_wrap = (m_c == 0);
          m_c    = (m_c + MODV - 1) % MODV;
        end else begin
          m_wrap = (m_c == MODV - 1);
          m_c    = (m_c + 1) % MODV;
        end
      end
      m_tick = stp;
      if (m_r == RC) begin
        m_r = 0; m_s = (m_s + 1) % DG;
      end else begin
        m_r++;
      end
    end
    #1;
    es = '0;
    es[m_s] = 1'b1;
    chk("bcd_count", 32'(bcd_count), 32'(to_bcd(m_c)));
    chk("tick",      32'(tick),      32'(m_tick));
    chk("wrap",      32'(wrap),      32'(m_wrap));
    chk("digit_sel", 32'(digit_sel), 32'(es));
    chk("segments",  32'(segments),  32'(SEG[digit_of(m_c, m_s)]));
  endtask

  // Count up (no pause/clear) until the model count equals target.
  task automatic run_to(input int target);
    int n;
    n = 0;
    while (m_c != target && n < 4 * (MODV + 2)) begin
      cyc(0, 0, 0, 0);
      n++;
    end
    chk("run_to", 32'(bcd_count), 32'(to_bcd(target)));
  endtask

  // Run idle cycles with the given direction until the model issues one step.
  task automatic one_step(input bit dn);
    int n;
    n = 0;
    do begin
      cyc(0, 0, 0, dn);
      n++;
    end while (!m_tick && n < MC + 2);
    chk("step_seen", 32'(tick), 32'd1);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; pause = 1'b0; down = 1'b0;

    // Reset dominates whatever else is driven.
    for (int i = 0; i < 3; i++)
      cyc(1, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));

    // First two steps after release land on the 4th and 8th edges.
    for (int k = 1; k <= 8; k++) begin
      cyc(0, 0, 0, 0);
      if (k == 4) begin
        chk("first_tick", 32'(tick), 32'd1);
        chk("first_bcd", 32'(bcd_count), 32'h01);
      end
      if (k == 8) begin
        chk("second_tick", 32'(tick), 32'd1);
        chk("second_bcd", 32'(bcd_count), 32'h02);
      end
    end

    // Up wrap from all-nines.
    run_to(99);
    one_step(0);
    chk("wrap99_bcd", 32'(bcd_count), 32'h00);
    chk("wrap99_wrap", 32'(wrap), 32'd1);
    cyc(0, 0, 0, 0);
    chk("wrap99_once", 32'(wrap), 32'd0);

    // Direction handling.
    cyc(0, 1, 0, 0);
    run_to(10);
`ifdef SEG7_MUX_DOWN_EN
    one_step(1);
    chk("down_10_09", 32'(bcd_count), 32'h09);
    one_step(1);
    chk("down_09_08", 32'(bcd_count), 32'h08);
    cyc(0, 1, 0, 1);
    one_step(1);
    chk("down_wrap_bcd", 32'(bcd_count), 32'h99);
    chk("down_wrap_flag", 32'(wrap), 32'd1);
`else
    one_step(1);
    chk("down_ignored_11", 32'(bcd_count), 32'h11);
    one_step(1);
    chk("down_ignored_12", 32'(bcd_count), 32'h12);
`endif

    // Pause freezes counting while the scan keeps running.
    for (int i = 0; i < 20; i++) cyc(0, 0, 1, 1'($urandom_range(1)));

    // Clear on the prescaler terminal edge wins over the step.
    cyc(0, 0, 0, 0);
    while (m_p != MC) cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    chk("clear_term_tick", 32'(tick), 32'd0);
    chk("clear_term_bcd", 32'(bcd_count), 32'h00);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);

    // Show 47 and watch both scan positions.
    cyc(0, 1, 0, 0);
    run_to(47);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 1, 0);
      chk("seg47", 32'(segments), (m_s == 0) ? 32'b0000111 : 32'b1100110);
    end

    // Reset asserted mid-count.
    cyc(1, 1, 1, 0);
    chk("midreset_sel", 32'(digit_sel), 32'd1);
    chk("midreset_seg", 32'(segments), 32'b0111111);

    // Random traffic.
    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(199) == 0), ($urandom_range(39) == 0),
          ($urandom_range(3) == 0), 1'($urandom_range(1)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
